riscv_rom_arbiter: RTL and testbench
====================================

RISCV_ROM_ARBITER -- requirements
Module: riscv_rom_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 32, SHALL set the ROM data width in bits.
REQ-002 Parameter ADDR_DEPTH, default 10, SHALL set the ROM address width in bits.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 A_REQ  input  1  SHALL be the read request from requester A (instruction fetch).
REQ-006 A_ADDR  input  ADDR_DEPTH  SHALL be requester A's read address; the requester holds it stable while A_REQ=1 and A_GNT=0.
REQ-007 A_GNT  output  1  SHALL pulse for one cycle when A's request is accepted.
REQ-008 A_RVALID  output  1  SHALL pulse for one cycle when A_RDATA holds the response.
REQ-009 A_RDATA  output  WORD_SIZE  SHALL carry the read data for requester A.
REQ-010 B_REQ, B_ADDR, B_GNT, B_RVALID, B_RDATA SHALL mirror REQ-005..009 for requester B (data load).
REQ-011 ROM_ENABLE  output  1  SHALL drive the enable input of the synchronous ROM.
REQ-012 ROM_ADDR  output  ADDR_DEPTH  SHALL drive the ROM address.
REQ-013 ROM_DATA  input  WORD_SIZE  SHALL receive the ROM output, which the ROM registers on the CLK edge where ROM_ENABLE=1.

Function
REQ-014 The FSM SHALL have three states: IDLE, ISSUE and CAPTURE.
REQ-015 IDLE with no request SHALL stay in IDLE.
REQ-016 IDLE with any request SHALL arbitrate, latch the winner's address and owner ID, assert the winner's GNT combinationally in that cycle, and go to ISSUE.
REQ-017 ISSUE SHALL drive ROM_ENABLE=1 and ROM_ADDR=latched address from registers, then go to CAPTURE unconditionally.
REQ-018 CAPTURE SHALL register ROM_DATA into the owner's RDATA, set the owner's RVALID for the following cycle, and go to IDLE.
REQ-019 Latency: GNT in cycle t SHALL give RVALID in cycle t+3. Peak throughput: one access per 3 cycles.
REQ-020 A new grant SHALL be allowed in the same cycle an RVALID is high.
REQ-021 Arbitration SHALL be round-robin via a LAST_OWNER register, updated on each grant. The owner is A or B.
REQ-022 When A and B request in the same cycle, the requester that is not LAST_OWNER SHALL win.
REQ-023 When only one requester is active, that requester SHALL win regardless of LAST_OWNER.
REQ-024 Outside ISSUE, ROM_ENABLE SHALL be 0 and ROM_ADDR SHALL hold its last value.
REQ-025 GNT SHALL never be asserted outside IDLE. At most one GNT SHALL be high per cycle.
REQ-026 Requests arriving in ISSUE or CAPTURE SHALL be ignored until IDLE; the requester keeps REQ high.
REQ-027 Deasserting REQ before GNT SHALL be legal and SHALL cause no access.
REQ-028 RDATA of a port SHALL hold its value until that port's next response; the other port's response SHALL NOT disturb it.
REQ-029 At most one RVALID SHALL be high per cycle, and only for the port that owned the access.

Reset
REQ-030 RESET=1 SHALL force the state to IDLE immediately, independent of CLK.
REQ-031 RESET=1 SHALL clear ROM_ENABLE, ROM_ADDR, A_GNT/B_GNT, A_RVALID/B_RVALID and A_RDATA/B_RDATA to 0.
REQ-032 RESET=1 SHALL set LAST_OWNER to B, so that A wins the first tie.
REQ-033 Reset during ISSUE or CAPTURE SHALL abort the access; no RVALID SHALL follow for it.
REQ-034 Outputs SHALL resume normal behaviour on the first CLK edge after RESET falls.

Verification
REQ-035 Single A read: A_REQ=1, A_ADDR=0x005, ROM[5]=0x00A00093 -> A_GNT at t, ROM_ENABLE=1 with ROM_ADDR=0x005 at t+1, A_RVALID=1 with A_RDATA=0x00A00093 at t+3, no B activity.
REQ-036 Tie after reset: A_REQ=B_REQ=1 held -> grants alternate A,B,A,B at 3-cycle spacing; each RVALID goes to the matching port with the correct ROM word.
REQ-037 Back-to-back on one port: B_REQ held with address changed after each grant (0x010, 0x011) -> B_GNT at t and t+3; B_RVALID at t+3 and t+6.
REQ-038 Late arrival: A granted at t, B_REQ rises at t+1 -> B_GNT not before t+3; A_RDATA unchanged by B's response.
REQ-039 Reset mid-access: RESET pulsed during CAPTURE -> all outputs 0 asynchronously, no RVALID afterwards, first later tie granted to A.
REQ-040 Withdrawn request: B_REQ high only in a cycle where the FSM is in ISSUE -> no B_GNT, no ROM_ENABLE pulse for B.

Source files
------------

// File: rtl/riscv_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_rom_arbiter
// Purpose  : Two-port round-robin arbiter in front of a single synchronous
//            ROM. Port A is instruction fetch, port B is data load. Each
//            access takes three cycles: grant, issue to ROM, capture data.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_rom_arbiter #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_DEPTH = 10
) (
  input  logic                  CLK,
  input  logic                  RESET,
  // Requester A (instruction fetch)
  input  logic                  A_REQ,
  input  logic [ADDR_DEPTH-1:0] A_ADDR,
  output logic                  A_GNT,
  output logic                  A_RVALID,
  output logic [WORD_SIZE-1:0]  A_RDATA,
  // Requester B (data load)
  input  logic                  B_REQ,
  input  logic [ADDR_DEPTH-1:0] B_ADDR,
  output logic                  B_GNT,
  output logic                  B_RVALID,
  output logic [WORD_SIZE-1:0]  B_RDATA,
  // Synchronous ROM
  output logic                  ROM_ENABLE,
  output logic [ADDR_DEPTH-1:0] ROM_ADDR,
  input  logic [WORD_SIZE-1:0]  ROM_DATA
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  state_t                  state_q, state_d;
  logic                    last_owner_q;   // owner of the most recent grant
  logic                    rom_en_q;
  logic [ADDR_DEPTH-1:0]   rom_addr_q;
  logic                    a_rvalid_q, b_rvalid_q;
  logic [WORD_SIZE-1:0]    a_rdata_q, b_rdata_q;
  logic                    a_gnt_d, b_gnt_d;
  logic                    grant_d;
  logic                    b_wins_d;

  // B wins when it is the only requester, or on a tie when A went last.
  assign b_wins_d = B_REQ && (!A_REQ || (last_owner_q == OWNER_A));
  assign grant_d  = a_gnt_d | b_gnt_d;

  // Next-state and combinational grant; grants are only issued from IDLE
  // and are suppressed while reset is asserted.
  always_comb begin
    state_d = state_q;
    a_gnt_d = 1'b0;
    b_gnt_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((A_REQ || B_REQ) && !RESET) begin
          state_d = S_ISSUE;
          if (b_wins_d) b_gnt_d = 1'b1;
          else          a_gnt_d = 1'b1;
        end
      end
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Latch the winner at grant time and present it to the ROM during ISSUE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_owner_q <= OWNER_B;   // so A wins the first tie
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
    end else begin
      rom_en_q <= grant_d;
      if (grant_d) begin
        last_owner_q <= b_gnt_d ? OWNER_B : OWNER_A;
        rom_addr_q   <= b_gnt_d ? B_ADDR : A_ADDR;
      end
    end
  end

  // In CAPTURE, route the ROM word to the owner and flag it for one cycle;
  // the other port's data register is left untouched.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= (state_q == S_CAPTURE) && (last_owner_q == OWNER_A);
      b_rvalid_q <= (state_q == S_CAPTURE) && (last_owner_q == OWNER_B);
      if ((state_q == S_CAPTURE) && (last_owner_q == OWNER_A)) a_rdata_q <= ROM_DATA;
      if ((state_q == S_CAPTURE) && (last_owner_q == OWNER_B)) b_rdata_q <= ROM_DATA;
    end
  end

  assign A_GNT      = a_gnt_d;
  assign B_GNT      = b_gnt_d;
  assign A_RVALID   = a_rvalid_q;
  assign B_RVALID   = b_rvalid_q;
  assign A_RDATA    = a_rdata_q;
  assign B_RDATA    = b_rdata_q;
  assign ROM_ENABLE = rom_en_q;
  assign ROM_ADDR   = rom_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_rom_arbiter
// Purpose  : Directed self-checking bench for riscv_rom_arbiter with a
//            behavioural synchronous ROM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_rom_arbiter;

  localparam int WORD_SIZE  = 32;
  localparam int ADDR_DEPTH = 10;

  logic                  CLK = 1'b0;
  logic                  RESET = 1'b1;
  logic                  A_REQ = 1'b0, B_REQ = 1'b0;
  logic [ADDR_DEPTH-1:0] A_ADDR = '0, B_ADDR = '0;
  logic                  A_GNT, B_GNT, A_RVALID, B_RVALID;
  logic [WORD_SIZE-1:0]  A_RDATA, B_RDATA;
  logic                  ROM_ENABLE;
  logic [ADDR_DEPTH-1:0] ROM_ADDR;
  logic [WORD_SIZE-1:0]  ROM_DATA = '0;

  int n_pass  = 0;
  int n_total = 0;

  riscv_rom_arbiter #(.WORD_SIZE(WORD_SIZE), .ADDR_DEPTH(ADDR_DEPTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
    .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
    .ROM_ENABLE(ROM_ENABLE), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA)
  );

  always #5 CLK = ~CLK;

  // ROM contents: address 5 holds a real instruction, the rest a tagged pattern.
  function automatic logic [WORD_SIZE-1:0] rom_word(input logic [ADDR_DEPTH-1:0] a);
    if (a == 10'd5) return 32'h00A0_0093;
    return {8'hC3, 14'd0, a};
  endfunction

  // Synchronous ROM: output registered on the edge where enable is high.
  always @(posedge CLK) if (ROM_ENABLE) ROM_DATA <= rom_word(ROM_ADDR);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #2;
    chk("rst_rom_en",  ROM_ENABLE, 0);
    chk("rst_rom_addr", ROM_ADDR,  0);
    chk("rst_gnt",     {A_GNT, B_GNT}, 0);
    chk("rst_rvalid",  {A_RVALID, B_RVALID}, 0);
    chk("rst_rdata",   {A_RDATA, B_RDATA}, 0);
    @(negedge CLK); RESET = 1'b0;
    tick();

    // ---------------- tie after reset: A,B,A,B ----------------
    A_REQ = 1; B_REQ = 1; A_ADDR = 10'h020; B_ADDR = 10'h030; #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tie_gntA_%0d", k), A_GNT, (k % 2 == 0));
      chk($sformatf("tie_gntB_%0d", k), B_GNT, (k % 2 == 1));
      if (k > 0) begin
        chk($sformatf("tie_rvA_%0d", k), A_RVALID, (k % 2 == 1));
        chk($sformatf("tie_rvB_%0d", k), B_RVALID, (k % 2 == 0));
      end
      if (k == 1) chk("tie_rdA_1", A_RDATA, 32'hC300_0020);
      if (k == 2) chk("tie_rdB_2", B_RDATA, 32'hC300_0030);
      tick(); #1;
      chk($sformatf("tie_issue_en_%0d", k), ROM_ENABLE, 1);
      chk($sformatf("tie_issue_gnt_%0d", k), {A_GNT, B_GNT}, 0);
      tick(); #1;
      chk($sformatf("tie_capt_gnt_%0d", k), {A_GNT, B_GNT}, 0);
      tick();
      if (k == 3) begin A_REQ = 0; B_REQ = 0; end
      #1;
    end
    chk("tie_last_rvB", {A_RVALID, B_RVALID}, 2'b01);
    chk("tie_last_rdB", B_RDATA, 32'hC300_0030);
    chk("tie_rdA_held", A_RDATA, 32'hC300_0020);

    // ---------------- single A read ----------------
    tick();
    A_REQ = 1; A_ADDR = 10'h005; #1;
    chk("sa_gnt", {A_GNT, B_GNT}, 2'b10);
    tick(); A_REQ = 0; #1;
    chk("sa_en",   ROM_ENABLE, 1);
    chk("sa_addr", ROM_ADDR, 10'h005);
    tick(); #1;
    chk("sa_en_off", ROM_ENABLE, 0);
    chk("sa_addr_hold", ROM_ADDR, 10'h005);
    chk("sa_no_rv_early", A_RVALID, 0);
    tick(); #1;
    chk("sa_rv", {A_RVALID, B_RVALID}, 2'b10);
    chk("sa_rdata", A_RDATA, 32'h00A0_0093);
    chk("sa_b_untouched", B_RDATA, 32'hC300_0030);
    tick(); #1;
    chk("sa_rv_pulse", A_RVALID, 0);

    // ---------------- back-to-back on B ----------------
    B_REQ = 1; B_ADDR = 10'h010; #1;
    chk("bb_gnt0", B_GNT, 1);
    tick(); B_ADDR = 10'h011; #1;
    chk("bb_no_gnt1", B_GNT, 0);
    tick(); #1;
    chk("bb_no_gnt2", B_GNT, 0);
    tick(); #1;
    chk("bb_gnt3", B_GNT, 1);
    chk("bb_rv3", B_RVALID, 1);
    chk("bb_rd3", B_RDATA, 32'hC300_0010);
    tick(); B_REQ = 0; #1;
    chk("bb_addr4", ROM_ADDR, 10'h011);
    tick(); tick(); #1;
    chk("bb_rv6", B_RVALID, 1);
    chk("bb_rd6", B_RDATA, 32'hC300_0011);
    chk("bb_a_held", A_RDATA, 32'h00A0_0093);

    // ---------------- late arrival ----------------
    tick();
    A_REQ = 1; A_ADDR = 10'h040; #1;
    chk("la_gntA", A_GNT, 1);
    tick(); A_REQ = 0; B_REQ = 1; B_ADDR = 10'h041; #1;
    chk("la_no_gntB1", B_GNT, 0);
    tick(); #1;
    chk("la_no_gntB2", B_GNT, 0);
    tick(); #1;
    chk("la_gntB3", B_GNT, 1);
    chk("la_rvA3", {A_RVALID, B_RVALID}, 2'b10);
    chk("la_rdA3", A_RDATA, 32'hC300_0040);
    tick(); B_REQ = 0;
    tick(); tick(); #1;
    chk("la_rvB6", {A_RVALID, B_RVALID}, 2'b01);
    chk("la_rdB6", B_RDATA, 32'hC300_0041);
    chk("la_rdA_held", A_RDATA, 32'hC300_0040);

    // ---------------- withdrawn request during ISSUE ----------------
    tick();
    A_REQ = 1; A_ADDR = 10'h050; #1;
    chk("wd_gntA", A_GNT, 1);
    tick(); A_REQ = 0; B_REQ = 1; B_ADDR = 10'h060; #1;
    chk("wd_no_gntB", B_GNT, 0);
    chk("wd_en_A", ROM_ENABLE, 1);
    chk("wd_addr_A", ROM_ADDR, 10'h050);
    tick(); B_REQ = 0; #1;
    chk("wd_en_off2", ROM_ENABLE, 0);
    tick(); #1;
    chk("wd_rvA", {A_RVALID, B_RVALID}, 2'b10);
    chk("wd_gnt_none", {A_GNT, B_GNT}, 0);
    tick(); #1;
    chk("wd_en_off4", ROM_ENABLE, 0);
    chk("wd_addr_hold", ROM_ADDR, 10'h050);
    tick(); #1;
    chk("wd_quiet5", {ROM_ENABLE, A_GNT, B_GNT, A_RVALID, B_RVALID}, 0);

    // ---------------- reset mid-access ----------------
    B_REQ = 1; B_ADDR = 10'h070; #1;
    chk("rm_gntB", B_GNT, 1);
    tick(); B_REQ = 0;
    tick();                                   // now in CAPTURE
    RESET = 1; A_REQ = 1; B_REQ = 1; A_ADDR = 10'h080; B_ADDR = 10'h090; #1;
    chk("rm_async_en",    ROM_ENABLE, 0);
    chk("rm_async_addr",  ROM_ADDR, 0);
    chk("rm_async_gnt",   {A_GNT, B_GNT}, 0);
    chk("rm_async_rv",    {A_RVALID, B_RVALID}, 0);
    chk("rm_async_rdata", {A_RDATA, B_RDATA}, 0);
    tick(); #1;
    chk("rm_no_rv", {A_RVALID, B_RVALID}, 0);
    @(negedge CLK); RESET = 0; #1;
    chk("rm_tie_A", {A_GNT, B_GNT}, 2'b10);
    tick(); A_REQ = 0; B_REQ = 0; #1;
    chk("rm_addr", ROM_ADDR, 10'h080);
    chk("rm_no_rvB", B_RVALID, 0);
    tick(); tick(); #1;
    chk("rm_rvA", {A_RVALID, B_RVALID}, 2'b10);
    chk("rm_rdA", A_RDATA, 32'hC300_0080);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
